// File: rtl/mfa_share_arb.sv
// mfa_share_arb: round-robin owner arbiter for the shared MFA unit.
// One requester owns the MFA unit for a complete store/snoop/restore
// sequence; every other active requester sees nack until release.
// Optional watchdog: define MFA_ARB_TIMEOUT_EN to force release of a hung
// owner after TIMEOUT_CYC cycles of ownership.

// Per-requester nack cell: requesting while someone else holds the unit.
module mfa_share_arb_nack_cell (
  input  logic req,
  input  logic grant,
  input  logic active,
  output logic nack
);
  assign nack = req & active & ~grant;
endmodule

module mfa_share_arb #(
  parameter int NUM_REQ     = 4,
  parameter int WIDTH_SEL   = $clog2(NUM_REQ),
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   I_Req,
  input  logic                 I_Idle_MFA,
  input  logic                 I_End_MFA,
  output logic [NUM_REQ-1:0]   O_Grant,
  output logic [WIDTH_SEL-1:0] O_Sel,
  output logic                 O_Active,
  output logic [NUM_REQ-1:0]   O_Nack,
  output logic                 O_Timeout
);

  typedef enum logic [1:0] {ARB_IDLE, ARB_WAIT, ARB_RUN, ARB_REL} arb_state_t;

  arb_state_t           state;
  logic [WIDTH_SEL-1:0] ptr;
  logic                 pick_vld;
  logic [WIDTH_SEL-1:0] pick_idx;
  logic                 wd_expire;
  logic                 release_now;
  logic [WIDTH_SEL-1:0] ptr_next;

  // Rotating priority scan: first set request at or above ptr, with wrap.
  always_comb begin
    logic [WIDTH_SEL:0] sum;
    pick_vld = 1'b0;
    pick_idx = '0;
    sum      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, ptr} + (WIDTH_SEL+1)'(k);
      if (sum >= (WIDTH_SEL+1)'(NUM_REQ)) sum = sum - (WIDTH_SEL+1)'(NUM_REQ);
      if (!pick_vld && I_Req[sum[WIDTH_SEL-1:0]]) begin
        pick_vld = 1'b1;
        pick_idx = sum[WIDTH_SEL-1:0];
      end
    end
  end

  // Release conditions: withdraw before start, end/abort while running,
  // or watchdog expiry in either owned state. End in WAIT is ignored.
  always_comb begin
    release_now = 1'b0;
    case (state)
      ARB_WAIT: release_now = wd_expire | (I_Idle_MFA & ~I_Req[O_Sel]);
      ARB_RUN:  release_now = wd_expire | I_End_MFA | I_Idle_MFA;
      default:  release_now = 1'b0;
    endcase
  end

  assign ptr_next = (O_Sel == WIDTH_SEL'(NUM_REQ-1)) ? '0 : O_Sel + 1'b1;

  // Ownership FSM with registered grant/sel/active.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= ARB_IDLE;
      O_Grant  <= '0;
      O_Sel    <= '0;
      O_Active <= 1'b0;
      ptr      <= '0;
    end else if (release_now) begin
      state    <= ARB_REL;
      O_Grant  <= '0;
      O_Active <= 1'b0;
      ptr      <= ptr_next;
    end else begin
      case (state)
        ARB_IDLE: if (pick_vld) begin
          state    <= ARB_WAIT;
          O_Grant  <= NUM_REQ'(1) << pick_idx;
          O_Sel    <= pick_idx;
          O_Active <= 1'b1;
        end
        ARB_WAIT: if (!I_Idle_MFA) state <= ARB_RUN;
        ARB_RUN:  state <= ARB_RUN;
        default:  state <= ARB_IDLE;
      endcase
    end
  end

`ifdef MFA_ARB_TIMEOUT_EN
  localparam logic [12:0] WD_LAST = 13'(TIMEOUT_CYC - 1);
  logic [12:0] wd_cnt;

  assign wd_expire = O_Active & (wd_cnt == WD_LAST);
  // A genuine end in the expiry cycle wins and is not reported as a timeout.
  assign O_Timeout = wd_expire & ~((state == ARB_RUN) & I_End_MFA);

  // Ownership age: cleared on grant and on any release, counts while owned.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                             wd_cnt <= '0;
    else if (state == ARB_IDLE && pick_vld) wd_cnt <= '0;
    else if (release_now)                  wd_cnt <= '0;
    else if (O_Active)                     wd_cnt <= wd_cnt + 13'd1;
  end
`else
  assign wd_expire = 1'b0;
  // Always 0 for any legal TIMEOUT_CYC; keeps the parameter referenced so the
  // parameter list stays identical across both builds.
  assign O_Timeout = (TIMEOUT_CYC < 0);
`endif

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_nack
    mfa_share_arb_nack_cell u_nack (
      .req    (I_Req[i]),
      .grant  (O_Grant[i]),
      .active (O_Active),
      .nack   (O_Nack[i])
    );
  end

endmodule
